// File: rtl/ddr_refill_arbiter.sv
// ddr_refill_arbiter
//
// Shares the single DDR Wishbone slave port between two cache line-refill masters.
//   m0 : instruction cache refill path (read-only)
//   m1 : data cache refill / writeback path (read or write)
//
// The arbiter grants in round-robin order and holds the grant for a whole transaction.
// It returns ack to the owner only, and it aborts any transaction that the DDR side
// never acknowledges. Every transaction passes through three states:
//   IDLE  -> BUSY  -> DRAIN -> IDLE
// There are always two quiet bus cycles between transactions (DRAIN, then IDLE).
//
// Ports
//   clk, rst                   DDR-domain clock, asynchronous active-low reset
//   m0_addr/cyc/stb            master 0 request
//   m0_ack, m0_err             master 0 acknowledge / timeout abort
//   m1_addr/dout/we/cyc/stb    master 1 request
//   m1_ack, m1_err             master 1 acknowledge / timeout abort
//   m_din                      read data broadcast to both masters (= s_din)
//   s_addr/dout/we/cyc/stb     DDR slave request
//   s_din, s_ack               DDR slave response
//   owner                      00 none, 01 m0, 10 m1

module ddr_refill_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 512,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,

   input  logic [ADDR_W-1:0] m0_addr,
   input  logic              m0_cyc,
   input  logic              m0_stb,
   output logic              m0_ack,
   output logic              m0_err,

   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_dout,
   input  logic              m1_we,
   input  logic              m1_cyc,
   input  logic              m1_stb,
   output logic              m1_ack,
   output logic              m1_err,

   output logic [DATA_W-1:0] m_din,

   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_dout,
   output logic              s_we,
   output logic              s_cyc,
   output logic              s_stb,
   input  logic [DATA_W-1:0] s_din,
   input  logic              s_ack,

   output logic [1:0]        owner
);

   // Watchdog sizing. The counter only needs to reach TIMEOUT-1.
   localparam int unsigned      CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam bit               WDOG_EN   = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] WDOG_LAST = WDOG_EN ? CNT_W'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDrain
   } state_e;

   state_e state_q, state_d;

   logic [1:0]        owner_q;
   logic              last_grant_q;   // 1: m1 was granted last
   logic [ADDR_W-1:0] s_addr_q;
   logic [DATA_W-1:0] s_dout_q;
   logic              s_we_q;
   logic [CNT_W-1:0]  wdog_q;
   logic              m0_err_q;
   logic              m1_err_q;

   logic req0;
   logic req1;
   logic grant_any;
   logic grant_m1;
   logic own_cyc;
   logic wdog_hit;
   logic timeout_fire;

   assign req0      = m0_cyc & m0_stb;
   assign req1      = m1_cyc & m1_stb;
   assign grant_any = req0 | req1;

   // On a tie, the master that was not granted last wins.
   assign grant_m1 = req1 & (~req0 | ~last_grant_q);

   // The owner still holds its cycle. Dropping it aborts the transaction.
   assign own_cyc = (owner_q[0] & m0_cyc) | (owner_q[1] & m1_cyc);

   assign wdog_hit = WDOG_EN && (wdog_q == WDOG_LAST);

   // A timeout fires only when neither an ack nor an owner abort ends the cycle first.
   // This keeps ack and err mutually exclusive.
   assign timeout_fire = (state_q == StBusy) & wdog_hit & ~s_ack & own_cyc;

   // ---------------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (grant_any) state_d = StBusy;
         StBusy:  if (s_ack || !own_cyc || wdog_hit) state_d = StDrain;
         StDrain: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // ---------------------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------------------
   // The bus strobes and the ack routing come from the state alone. An asynchronous
   // reset therefore drops them at once, and an ack in flight is never delivered.
   always_comb begin
      s_cyc  = 1'b0;
      s_stb  = 1'b0;
      m0_ack = 1'b0;
      m1_ack = 1'b0;
      if (state_q == StBusy) begin
         s_cyc  = 1'b1;
         s_stb  = 1'b1;
         m0_ack = s_ack & owner_q[0];
         m1_ack = s_ack & owner_q[1];
      end
   end

   // ---------------------------------------------------------------------------------
   // Grant, request capture, watchdog and error pulses
   // ---------------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_q      <= 2'b00;
         last_grant_q <= 1'b1;
         s_addr_q     <= '0;
         s_dout_q     <= '0;
         s_we_q       <= 1'b0;
         wdog_q       <= '0;
         m0_err_q     <= 1'b0;
         m1_err_q     <= 1'b0;
      end else begin
         // The error pulse lands in the DRAIN cycle, one cycle after the hit is seen.
         m0_err_q <= timeout_fire & owner_q[0];
         m1_err_q <= timeout_fire & owner_q[1];

         unique case (state_q)
            StIdle: begin
               if (grant_any) begin
                  owner_q      <= grant_m1 ? 2'b10 : 2'b01;
                  last_grant_q <= grant_m1;
                  s_addr_q     <= grant_m1 ? m1_addr : m0_addr;
                  // The instruction path is read-only: write data and enable stay zero.
                  s_dout_q     <= grant_m1 ? m1_dout : '0;
                  s_we_q       <= grant_m1 & m1_we;
                  wdog_q       <= '0;
               end
            end
            StBusy: begin
               wdog_q <= wdog_q + CNT_W'(1);
               if (state_d == StDrain) begin
                  owner_q <= 2'b00;
               end
            end
            default: begin
               owner_q <= 2'b00;
            end
         endcase
      end
   end

   assign owner  = owner_q;
   assign s_addr = s_addr_q;
   assign s_dout = s_dout_q;
   assign s_we   = s_we_q;
   assign m0_err = m0_err_q;
   assign m1_err = m1_err_q;
   assign m_din  = s_din;

endmodule

// File: tb/tb_ddr_refill_arbiter.sv
// tb_ddr_refill_arbiter
//
// Self-checking bench for ddr_refill_arbiter. The arbiter is built with a short watchdog
// so that the timeout path can be reached. Expected values come from a transaction-level
// view of the arbiter:
//   - the grant goes to the requester, or to the non-last master when both request;
//   - the strobe rises one cycle after the request is presented;
//   - ack arrives after the chosen slave latency;
//   - two quiet cycles separate transactions.

module tb_ddr_refill_arbiter;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 512;
   localparam int          TO     = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [ADDR_W-1:0] m0_addr;
   logic              m0_cyc;
   logic              m0_stb;
   logic              m0_ack;
   logic              m0_err;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_dout;
   logic              m1_we;
   logic              m1_cyc;
   logic              m1_stb;
   logic              m1_ack;
   logic              m1_err;
   logic [DATA_W-1:0] m_din;
   logic [ADDR_W-1:0] s_addr;
   logic [DATA_W-1:0] s_dout;
   logic              s_we;
   logic              s_cyc;
   logic              s_stb;
   logic [DATA_W-1:0] s_din;
   logic              s_ack;
   logic [1:0]        owner;

   always #5 clk = ~clk;

   ddr_refill_arbiter #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .TIMEOUT(TO)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .m0_addr(m0_addr),
      .m0_cyc (m0_cyc),
      .m0_stb (m0_stb),
      .m0_ack (m0_ack),
      .m0_err (m0_err),
      .m1_addr(m1_addr),
      .m1_dout(m1_dout),
      .m1_we  (m1_we),
      .m1_cyc (m1_cyc),
      .m1_stb (m1_stb),
      .m1_ack (m1_ack),
      .m1_err (m1_err),
      .m_din  (m_din),
      .s_addr (s_addr),
      .s_dout (s_dout),
      .s_we   (s_we),
      .s_cyc  (s_cyc),
      .s_stb  (s_stb),
      .s_din  (s_din),
      .s_ack  (s_ack),
      .owner  (owner)
   );

   int         tests = 0;
   int         fails = 0;
   int         last_m = 1;     // model: master granted last (arbiter reset says m1)
   bit         pend0 = 1'b0;   // model: master holding a request
   bit         pend1 = 1'b0;
   logic [1:0] seen_owner;

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_d(input string tag, input logic [DATA_W-1:0] obs,
                        input logic [DATA_W-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] rand_line();
      logic [DATA_W-1:0] v;
      for (int i = 0; i < int'(DATA_W / 32); i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Round-robin rule: a lone requester wins; on a tie, the master not granted last wins.
   function automatic int pick(input bit r0, input bit r1, input int last);
      if (r0 && r1) return (last == 0) ? 1 : 0;
      return r1 ? 1 : 0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one transaction that starts in an IDLE cycle. The slave acks `lat` cycles after
   // the strobe rises. The call returns at the start of the next IDLE cycle.
   task automatic run_txn(input int lat);
      int                win;
      logic [ADDR_W-1:0] ea;
      logic [DATA_W-1:0] ed;
      logic              ew;
      logic [DATA_W-1:0] rd;
      logic [1:0]        eo;
      m0_cyc = pend0;
      m0_stb = pend0;
      m1_cyc = pend1;
      m1_stb = pend1;
      #1;
      chk_b("idle_cyc", s_cyc, 1'b0);
      win = pick(pend0, pend1, last_m);
      ea  = (win == 1) ? m1_addr : m0_addr;
      ed  = (win == 1) ? m1_dout : '0;
      ew  = (win == 1) ? m1_we : 1'b0;
      eo  = (win == 1) ? 2'b10 : 2'b01;
      tick();
      #1;
      seen_owner = owner;
      chk_d("grant_owner", DATA_W'(owner), DATA_W'(eo));
      chk_b("grant_stb", s_stb, 1'b1);
      chk_d("grant_addr", DATA_W'(s_addr), DATA_W'(ea));
      for (int k = 0; k < lat; k++) begin
         chk_b("wait_cyc", s_cyc, 1'b1);
         chk_b("wait_ack0", m0_ack, 1'b0);
         chk_b("wait_ack1", m1_ack, 1'b0);
         chk_b("wait_we", s_we, ew);
         chk_d("wait_dout", s_dout, ed);
         tick();
         #1;
      end
      rd    = rand_line();
      s_din = rd;
      s_ack = 1'b1;
      #1;
      chk_b("ack_m0", m0_ack, win == 0);
      chk_b("ack_m1", m1_ack, win == 1);
      chk_d("ack_din", m_din, rd);
      chk_b("ack_we", s_we, ew);
      chk_d("ack_dout", s_dout, ed);
      chk_b("ack_err", m0_err | m1_err, 1'b0);
      tick();
      s_ack = 1'b0;
      if (win == 1) begin
         pend1  = 1'b0;
         m1_cyc = 1'b0;
         m1_stb = 1'b0;
      end else begin
         pend0  = 1'b0;
         m0_cyc = 1'b0;
         m0_stb = 1'b0;
      end
      #1;
      chk_b("drain_cyc", s_cyc, 1'b0);
      chk_d("drain_owner", DATA_W'(owner), '0);
      chk_b("drain_ack", m0_ack | m1_ack, 1'b0);
      last_m = win;
      tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: bench did not reach its summary, required to finish");
      $fatal(1);
   end

   initial begin
      // Reset held for three cycles with both masters requesting.
      rst     = 1'b0;
      m0_addr = $urandom;
      m1_addr = $urandom;
      m1_dout = rand_line();
      m1_we   = 1'b1;
      m0_cyc  = 1'b1;
      m0_stb  = 1'b1;
      m1_cyc  = 1'b1;
      m1_stb  = 1'b1;
      s_ack   = 1'b0;
      s_din   = '0;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk_b("rst_cyc", s_cyc, 1'b0);
         chk_b("rst_stb", s_stb, 1'b0);
         chk_b("rst_we", s_we, 1'b0);
         chk_b("rst_ack", m0_ack | m1_ack, 1'b0);
         chk_b("rst_err", m0_err | m1_err, 1'b0);
         chk_d("rst_owner", DATA_W'(owner), '0);
         chk_d("rst_addr", DATA_W'(s_addr), '0);
         chk_d("rst_dout", s_dout, '0);
      end
      rst = 1'b1;
      #1;
      chk_b("rel_cyc", s_cyc, 1'b0);
      tick();
      chk_b("rel_grant_cyc", s_cyc, 1'b1);
      chk_d("rel_grant_owner", DATA_W'(owner), DATA_W'(2'b01));
      chk_d("rel_grant_addr", DATA_W'(s_addr), DATA_W'(m0_addr));
      // Reset in the middle of a transaction, with the ack already on the bus.
      s_ack = 1'b1;
      #1;
      chk_b("mid_ack_seen", m0_ack, 1'b1);
      rst = 1'b0;
      #1;
      chk_b("mid_rst_ack", m0_ack, 1'b0);
      chk_b("mid_rst_cyc", s_cyc, 1'b0);
      chk_d("mid_rst_owner", DATA_W'(owner), '0);
      chk_d("mid_rst_addr", DATA_W'(s_addr), '0);
      s_ack  = 1'b0;
      m0_cyc = 1'b0;
      m0_stb = 1'b0;
      m1_cyc = 1'b0;
      m1_stb = 1'b0;
      tick();
      rst    = 1'b1;
      last_m = 1;
      tick();

      // Single read by m0.
      pend0   = 1'b1;
      m0_addr = 32'h0000_1240;
      run_txn(5);

      // Write by m1.
      pend1   = 1'b1;
      m1_addr = 32'h0800_0040;
      m1_we   = 1'b1;
      m1_dout = rand_line();
      run_txn(3);

      // Contention: both keep requesting, so grants must alternate, starting with m0.
      for (int i = 0; i < 6; i++) begin
         if (!pend0) begin
            pend0   = 1'b1;
            m0_addr = $urandom;
         end
         if (!pend1) begin
            pend1   = 1'b1;
            m1_addr = $urandom;
            m1_dout = rand_line();
            m1_we   = 1'($urandom_range(0, 1));
         end
         run_txn(2);
         chk_d("rr_order", DATA_W'(seen_owner), DATA_W'((i % 2 == 0) ? 2'b01 : 2'b10));
      end

      // Timeout: m0 is still pending and owns the bus, the slave never acks, and m1 joins
      // while m0 is busy.
      pend1  = 1'b0;
      m1_cyc = 1'b0;
      m1_stb = 1'b0;
      m0_cyc = 1'b1;
      m0_stb = 1'b1;
      #1;
      chk_b("to_idle", s_cyc, 1'b0);
      tick();
      for (int k = 0; k <= TO + 1; k++) begin
         if (k == 2) begin
            pend1   = 1'b1;
            m1_addr = $urandom;
            m1_dout = rand_line();
            m1_we   = 1'b1;
            m1_cyc  = 1'b1;
            m1_stb  = 1'b1;
         end
         if (k == TO) begin
            pend0  = 1'b0;
            m0_cyc = 1'b0;
            m0_stb = 1'b0;
         end
         #1;
         chk_b("to_err0", m0_err, k == TO);
         chk_b("to_err1", m1_err, 1'b0);
         chk_b("to_cyc", s_cyc, k < TO);
         chk_b("to_ack", m0_ack | m1_ack, 1'b0);
         if (k < TO + 1) tick();
      end
      last_m = 0;
      run_txn(4);   // m1 must be granted two cycles after the err pulse

      // Abort: m1 drops cyc three cycles into BUSY.
      m1_addr = $urandom;
      m1_we   = 1'b0;
      m1_cyc  = 1'b1;
      m1_stb  = 1'b1;
      tick();
      for (int k = 0; k < 6; k++) begin
         if (k == 3) begin
            m1_cyc = 1'b0;
            m1_stb = 1'b0;
         end
         #1;
         chk_b("ab_cyc", s_cyc, k <= 3);
         chk_b("ab_ack", m1_ack, 1'b0);
         chk_b("ab_err", m1_err, 1'b0);
         chk_d("ab_owner", DATA_W'(owner), DATA_W'((k <= 3) ? 2'b10 : 2'b00));
         tick();
      end
      last_m = 1;

      // Abort by m0 in the same cycle as the slave ack: the ack is still forwarded.
      m0_addr = $urandom;
      m0_cyc  = 1'b1;
      m0_stb  = 1'b1;
      tick();
      tick();
      m0_cyc = 1'b0;
      m0_stb = 1'b0;
      s_din  = rand_line();
      s_ack  = 1'b1;
      #1;
      chk_b("abk_ack0", m0_ack, 1'b1);
      chk_b("abk_ack1", m1_ack, 1'b0);
      chk_d("abk_din", m_din, s_din);
      tick();
      s_ack = 1'b0;
      #1;
      chk_b("abk_drain", s_cyc, 1'b0);
      chk_b("abk_err", m0_err, 1'b0);
      tick();
      last_m = 0;

      // Random traffic against the round-robin model.
      for (int it = 0; it < 24; it++) begin
         if (!pend0 && ($urandom_range(0, 1) == 1)) begin
            pend0   = 1'b1;
            m0_addr = $urandom;
         end
         if (!pend1 && ($urandom_range(0, 1) == 1)) begin
            pend1   = 1'b1;
            m1_addr = $urandom;
            m1_dout = rand_line();
            m1_we   = 1'($urandom_range(0, 1));
         end
         if (!pend0 && !pend1) begin
            pend0   = 1'b1;
            m0_addr = $urandom;
         end
         if (!pend1) m1_addr = $urandom;
         run_txn(int'($urandom_range(0, 10)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
